bias_weight_reader: RTL and testbench
=====================================

Name: bias_weight_reader

Overview:
- Read-out end of the bias/weight bundle stream. Accepts one parallel bundle per handshake: NC*NP weights followed by NC biases.
- Serialises the bundle into one WD-bit word per beat on a narrow valid/ready stream. The host/debug side uses this stream to dump trained parameters.
- Sits downstream of the bias/weight store's BS port. Only accepts a bundle in inference mode.

Parameters:
- NP, 4, previous-layer neurons (weights per neuron)
- NC, 4, current-layer neurons
- WD, 4, bit width of each weight/bias word

Ports:
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset; asynchronous assert, active-low (0 = reset)
- iMode  in  1  0 = inference/readout allowed, 1 = training (no new capture)
- iValid_BS  in  1  bundle valid
- oReady_BS  out  1  bundle ready (registered)
- iData_BS  in  NC*NP*WD+NC*WD  bundle; weight(c,p) at [(c*NP+p)*WD +: WD]; bias c at [NC*NP*WD+c*WD +: WD]
- oValid_OS  out  1  word valid
- iReady_OS  in  1  word ready
- oData_OS  out  WD  current word
- oIndex_OS  out  $clog2(NC*(NP+1))  beat index 0..N-1
- oLast_OS  out  1  high on beat N-1

Behaviour:
- N = NC*(NP+1) beats per bundle.
- Beat order per neuron c = 0..NC-1: weight(c,0)..weight(c,NP-1), then bias c. Beat k maps to c = k/(NP+1), j = k%(NP+1); j == NP selects the bias.
- Reset (iRST=0, async):
  - state=IDLE, counter=0, bundle register=0.
  - oValid_OS=0, oReady_BS=0 while reset is held.
  - oReady_BS=1 from the first edge after release, if iMode=0.
- FSM state IDLE:
  - oReady_BS = !iMode, registered, i.e. updated at each edge from the sampled iMode.
  - On iValid_BS && oReady_BS at an edge: capture iData_BS, set counter=0, go to SEND, set oReady_BS=0.
  - oValid_OS=1 in the cycle after the capture edge (latency 1).
- FSM state SEND:
  - oValid_OS=1.
  - oData_OS = selected word of the held bundle, for oIndex_OS = counter.
  - oLast_OS = (counter == N-1).
  - Each edge with iReady_OS=1 advances the counter. An accept on the last beat goes to IDLE: counter=0, oValid_OS=0.
  - oReady_BS is re-evaluated from iMode at that same edge, so it is 1 in the next cycle if iMode=0.
- Stalls: while oValid_OS && !iReady_OS, oData_OS/oIndex_OS/oLast_OS hold stable. The bundle register is never modified during SEND.
- No combinational path from iReady_OS to oReady_BS. The minimum bundle period is N+1 cycles.
- iMode=1 during SEND: readout completes normally; only a new capture is blocked.
- iMode toggling while in IDLE: oReady_BS follows with 1-cycle lag. A handshake counts only when the registered oReady_BS=1.
- Reset mid-SEND: the bundle is dropped; oValid_OS falls asynchronously.
- Edge cases: NP=1 gives 2 beats per neuron. NC=1,NP=1 gives N=2; oIndex_OS width is 1.

Decomposition:
- Shared package: localparam functions for N = NC*(NP+1) and the index width $clog2(N), plus the bundle bit-offset functions for weight(c,p) and bias(c). These offsets are reused by the bias/weight store and by benches.
- One natural sub-module: bias_weight_word_sel. It is a combinational mux from (bundle, index) to a WD-bit word using the package offset functions. The FSM, counter and registers stay in the top module.

Test Plan:
- NP=2, NC=2, WD=4; release reset with iMode=0 -> oReady_BS=0 during reset, 1 one cycle after release; oValid_OS=0.
- Apply iData_BS=24'h654321 with iValid_BS=1 for one cycle; iReady_OS=1 constantly -> next cycle oReady_BS=0, oValid_OS=1.
  - oData_OS sequence 1,2,5,3,4,6 on consecutive cycles.
  - oIndex_OS 0..5; oLast_OS only on value 6.
  - oReady_BS=1 the cycle after the last beat.
- Same bundle with iReady_OS=0 for 3 cycles at beat 2 -> oData_OS=5, oIndex_OS=2 held for the 3 cycles, then sequence continues 3,4,6; no beat lost or duplicated.
- Set iMode=1 mid-readout at beat 1 -> beats 2..5 still delivered. oReady_BS stays 0 after the last beat until iMode=0, then rises one cycle later. An iValid_BS offered meanwhile is not accepted.
- Assert iRST=0 at beat 3 -> oValid_OS drops immediately. After release, a new bundle 24'hFEDCBA yields A,B,E,C,D,F from index 0.
- Two back-to-back bundles with iValid_BS held high and iReady_OS=1 -> exactly 6 beats per bundle, one idle cycle between bundles (period 7 cycles), second bundle's data correct.

Source files
------------

// File: rtl/bias_weight_reader_pkg.sv
// Shared sizing and bundle-layout helpers for the bias/weight bundle stream.
package bias_weight_reader_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } bw_state_e;

  function automatic int unsigned bw_num_beats(input int unsigned nc, input int unsigned np);
    return nc * (np + 1);
  endfunction

  function automatic int unsigned bw_idx_width(input int unsigned nc, input int unsigned np);
    return (bw_num_beats(nc, np) > 1) ? $clog2(bw_num_beats(nc, np)) : 1;
  endfunction

  function automatic int unsigned bw_bundle_width(input int unsigned nc, input int unsigned np,
                                                  input int unsigned wd);
    return nc * np * wd + nc * wd;
  endfunction

  function automatic int unsigned bw_weight_off(input int unsigned c, input int unsigned p,
                                                input int unsigned np, input int unsigned wd);
    return (c * np + p) * wd;
  endfunction

  function automatic int unsigned bw_bias_off(input int unsigned c, input int unsigned nc,
                                              input int unsigned np, input int unsigned wd);
    return nc * np * wd + c * wd;
  endfunction

endpackage

// File: rtl/bias_weight_word_sel.sv
// Combinational mux picking beat `index` out of a bias/weight bundle.
module bias_weight_word_sel
  import bias_weight_reader_pkg::*;
#(
  parameter int unsigned NP = 4,
  parameter int unsigned NC = 4,
  parameter int unsigned WD = 4,
  localparam int unsigned N  = bw_num_beats(NC, NP),
  localparam int unsigned IW = bw_idx_width(NC, NP),
  localparam int unsigned BW = bw_bundle_width(NC, NP, WD)
) (
  input  logic [BW-1:0] bundle,
  input  logic [IW-1:0] index,
  output logic [WD-1:0] word_c
);

  logic [WD-1:0] words [N];

  // Beat k: neuron k/(NP+1); slot NP within each neuron is its bias.
  for (genvar k = 0; k < int'(N); k++) begin : g_word
    localparam int unsigned C   = k / (NP + 1);
    localparam int unsigned J   = k % (NP + 1);
    localparam int unsigned OFF = (J == NP) ? bw_bias_off(C, NC, NP, WD)
                                            : bw_weight_off(C, J, NP, WD);
    assign words[k] = bundle[OFF +: WD];
  end

  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (index == IW'(k)) word_c = words[k];
    end
  end

endmodule

// File: rtl/bias_weight_reader.sv
// Captures one parallel bias/weight bundle in inference mode and streams it out one word per beat.
module bias_weight_reader
  import bias_weight_reader_pkg::*;
#(
  parameter int unsigned NP = 4,
  parameter int unsigned NC = 4,
  parameter int unsigned WD = 4,
  localparam int unsigned N  = bw_num_beats(NC, NP),
  localparam int unsigned IW = bw_idx_width(NC, NP),
  localparam int unsigned BW = bw_bundle_width(NC, NP, WD)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iMode,
  input  logic          iValid_BS,
  output logic          oReady_BS,
  input  logic [BW-1:0] iData_BS,
  output logic          oValid_OS,
  input  logic          iReady_OS,
  output logic [WD-1:0] oData_OS,
  output logic [IW-1:0] oIndex_OS,
  output logic          oLast_OS
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  bw_state_e     state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bundle_q, bundle_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [WD-1:0] data_q, data_d;
  logic [WD-1:0] word_c;

  // Word for the next cycle is selected ahead so oData_OS comes straight from a flop.
  bias_weight_word_sel #(
    .NP(NP),
    .NC(NC),
    .WD(WD)
  ) u_word_sel (
    .bundle(bundle_d),
    .index (cnt_d),
    .word_c(word_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    last_d   = last_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = ~iMode;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (iValid_BS && ready_q) begin
          bundle_d = iData_BS;
          cnt_d    = '0;
          state_d  = ST_SEND;
          ready_d  = 1'b0;
          valid_d  = 1'b1;
          last_d   = (LAST_IDX == '0);
        end
      end
      ST_SEND: begin
        ready_d = 1'b0;
        valid_d = 1'b1;
        if (iReady_OS) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = ~iMode;
          end else begin
            cnt_d  = cnt_q + IW'(1);
            last_d = ((cnt_q + IW'(1)) == LAST_IDX);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    data_d = word_c;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bundle_q <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  assign oReady_BS = ready_q;
  assign oValid_OS = valid_q;
  assign oData_OS  = data_q;
  assign oIndex_OS = cnt_q;
  assign oLast_OS  = last_q;

endmodule

// File: tb/tb_bias_weight_reader.sv
// Scoreboard bench for bias_weight_reader with NP=2, NC=2, WD=4.
module tb_bias_weight_reader;

  localparam int unsigned NP = 2;
  localparam int unsigned NC = 2;
  localparam int unsigned WD = 4;
  localparam int unsigned N  = NC * (NP + 1);
  localparam int unsigned IW = 3;
  localparam int unsigned BW = NC * NP * WD + NC * WD;

  typedef struct {
    logic [WD-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iMode;
  logic          iValid_BS;
  logic          oReady_BS;
  logic [BW-1:0] iData_BS;
  logic          oValid_OS;
  logic          iReady_OS = 1'b1;
  logic [WD-1:0] oData_OS;
  logic [IW-1:0] oIndex_OS;
  logic          oLast_OS;

  logic  ready_force = 1'b1;
  logic  rand_ready  = 1'b0;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  beat_t exp_q[$];

  bias_weight_reader #(.NP(NP), .NC(NC), .WD(WD)) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iMode    (iMode),
    .iValid_BS(iValid_BS),
    .oReady_BS(oReady_BS),
    .iData_BS (iData_BS),
    .oValid_OS(oValid_OS),
    .iReady_OS(iReady_OS),
    .oData_OS (oData_OS),
    .oIndex_OS(oIndex_OS),
    .oLast_OS (oLast_OS)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(posedge iCLK) begin
    #2;
    iReady_OS = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: neuron by neuron, its NP weights then its bias, indices counting up.
  function automatic void model_push(input logic [BW-1:0] b);
    int unsigned k;
    beat_t       e;
    logic [BW-1:0] sh;
    k = 0;
    for (int unsigned c = 0; c < NC; c++) begin
      for (int unsigned j = 0; j <= NP; j++) begin
        if (j == NP) sh = b >> (NC * NP * WD + c * WD);
        else         sh = b >> ((c * NP + j) * WD);
        e.d = sh[WD-1:0];
        e.i = IW'(k);
        e.l = (k == N - 1);
        exp_q.push_back(e);
        k++;
      end
    end
  endfunction

  task automatic monitor();
    logic  stalled;
    beat_t prev;
    beat_t e;
    stalled = 1'b0;
    forever begin
      @(negedge iCLK);
      if (iRST && oValid_OS) begin
        if (stalled) begin
          check("hold_data", 32'(oData_OS), 32'(prev.d));
          check("hold_index", 32'(oIndex_OS), 32'(prev.i));
          check("hold_last", 32'(oLast_OS), 32'(prev.l));
        end
        if (iReady_OS) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h index %0d expected no beat", oData_OS, oIndex_OS);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(oData_OS), 32'(e.d));
            check("beat_index", 32'(oIndex_OS), 32'(e.i));
            check("beat_last", 32'(oLast_OS), 32'(e.l));
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev.d  = oData_OS;
          prev.i  = oIndex_OS;
          prev.l  = oLast_OS;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the capture edge with iValid_BS still high.
  task automatic send_bundle(input logic [BW-1:0] data, output int cap_cyc);
    logic ok;
    ok = 1'b0;
    iData_BS  = data;
    iValid_BS = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge iCLK);
      if (oReady_BS) begin
        model_push(data);
        ok = 1'b1;
      end
      @(posedge iCLK);
      #1;
    end
    cap_cyc = cyc;
    check("bundle_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      @(negedge iCLK);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_index(input int idx);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (oValid_OS && oIndex_OS == IW'(idx)) ok = 1'b1;
      else begin
        @(posedge iCLK);
        #1;
      end
    end
    check("reach_index", 32'(ok), 32'd1);
  endtask

  initial begin
    int c1, c2;
    iRST      = 1'b0;
    iMode     = 1'b0;
    iValid_BS = 1'b0;
    iData_BS  = '0;
    fork
      monitor();
    join_none

    // Reset and release
    repeat (3) @(negedge iCLK);
    check("reset_ready", 32'(oReady_BS), 32'd0);
    check("reset_valid", 32'(oValid_OS), 32'd0);
    @(posedge iCLK);
    #1 iRST = 1'b1;
    @(negedge iCLK);
    check("ready_before_edge", 32'(oReady_BS), 32'd0);
    @(negedge iCLK);
    check("ready_after_release", 32'(oReady_BS), 32'd1);
    check("idle_valid", 32'(oValid_OS), 32'd0);

    // Plain readout, sink always ready
    @(posedge iCLK);
    #1;
    send_bundle(24'h654321, c1);
    iValid_BS = 1'b0;
    @(negedge iCLK);
    check("send_ready_low", 32'(oReady_BS), 32'd0);
    check("send_valid_high", 32'(oValid_OS), 32'd1);
    check("first_word", 32'(oData_OS), 32'h1);
    drain();
    @(posedge iCLK);
    @(negedge iCLK);
    check("ready_after_last", 32'(oReady_BS), 32'd1);
    check("valid_after_last", 32'(oValid_OS), 32'd0);

    // Three-cycle stall on beat 2
    @(posedge iCLK);
    #1;
    send_bundle(24'h654321, c1);
    iValid_BS = 1'b0;
    wait_index(2);
    ready_force = 1'b0;
    repeat (3) begin
      @(negedge iCLK);
      check("stall_data", 32'(oData_OS), 32'h5);
      check("stall_index", 32'(oIndex_OS), 32'd2);
    end
    @(posedge iCLK);
    #1 ready_force = 1'b1;
    drain();

    // Training mode raised mid-readout blocks the next capture only
    @(posedge iCLK);
    #1;
    send_bundle(24'h9a7b3c, c1);
    iValid_BS = 1'b0;
    wait_index(1);
    iMode = 1'b1;
    drain();
    iValid_BS = 1'b1;
    iData_BS  = 24'h111111;
    repeat (4) begin
      @(negedge iCLK);
      check("mode_ready_low", 32'(oReady_BS), 32'd0);
      check("mode_no_capture", 32'(oValid_OS), 32'd0);
    end
    @(posedge iCLK);
    #1;
    iValid_BS = 1'b0;
    iMode     = 1'b0;
    @(negedge iCLK);
    check("mode_ready_lag", 32'(oReady_BS), 32'd0);
    @(negedge iCLK);
    check("mode_ready_back", 32'(oReady_BS), 32'd1);

    // Reset in the middle of a readout
    @(posedge iCLK);
    #1;
    send_bundle(BW'($urandom), c1);
    iValid_BS = 1'b0;
    wait_index(3);
    iRST = 1'b0;
    #1;
    check("rst_valid_drop", 32'(oValid_OS), 32'd0);
    check("rst_ready_drop", 32'(oReady_BS), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    check("rst_ready_back", 32'(oReady_BS), 32'd1);
    @(posedge iCLK);
    #1;
    send_bundle(24'hFEDCBA, c1);
    iValid_BS = 1'b0;
    @(negedge iCLK);
    check("post_rst_first", 32'(oData_OS), 32'hA);
    check("post_rst_index", 32'(oIndex_OS), 32'd0);
    drain();

    // Back-to-back bundles with iValid_BS held high
    @(posedge iCLK);
    #1;
    send_bundle(BW'($urandom), c1);
    send_bundle(BW'($urandom), c2);
    iValid_BS = 1'b0;
    check("bundle_period", 32'(c2 - c1), 32'(N + 1));
    drain();

    // Random data, random sink backpressure, random gaps
    rand_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      repeat ($urandom_range(0, 3)) @(posedge iCLK);
      #1;
      send_bundle(BW'($urandom), c1);
      iValid_BS = 1'b0;
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge iCLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
